// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for three producers feeding one regfile write port,
// with a pending-register scoreboard for hazard checks.
module regfile_wb_arbiter #(
   parameter int width = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         req_valid,
   input  logic [14:0]        req_addr,
   input  logic [3*width-1:0] req_data,
   output logic [2:0]         req_ready,
   output logic [4:0]         W_addr,
   output logic [width-1:0]   W_data,
   output logic               wr_enable,
   input  logic               issue_valid,
   input  logic [4:0]         issue_addr,
   input  logic [4:0]         A_addr,
   input  logic [4:0]         B_addr,
   output logic               A_busy,
   output logic               B_busy,
   output logic [31:0]        busy_vec
);

   logic [1:0]       rr_ptr;
   logic [1:0]       next_ptr;
   logic [2:0]       grant;
   logic             xfer;
   logic [4:0]       sel_addr;
   logic [width-1:0] sel_data;
   logic [31:0]      busy_q;
   logic [31:0]      busy_n;

   always_comb begin
      grant = 3'b000;
      case (rr_ptr)
         2'd1: begin
            if (req_valid[1])      grant = 3'b010;
            else if (req_valid[2]) grant = 3'b100;
            else if (req_valid[0]) grant = 3'b001;
         end
         2'd2: begin
            if (req_valid[2])      grant = 3'b100;
            else if (req_valid[0]) grant = 3'b001;
            else if (req_valid[1]) grant = 3'b010;
         end
         default: begin
            if (req_valid[0])      grant = 3'b001;
            else if (req_valid[1]) grant = 3'b010;
            else if (req_valid[2]) grant = 3'b100;
         end
      endcase
      // Nothing may be accepted while the block is held in reset.
      if (!reset) grant = 3'b000;
   end

   assign req_ready = grant;
   assign xfer      = |grant;

   always_comb begin
      sel_addr = 5'd0;
      sel_data = '0;
      next_ptr = rr_ptr;
      unique case (1'b1)
         grant[0]: begin
            sel_addr = req_addr[4:0];
            sel_data = req_data[width-1:0];
            next_ptr = 2'd1;
         end
         grant[1]: begin
            sel_addr = req_addr[9:5];
            sel_data = req_data[2*width-1:width];
            next_ptr = 2'd2;
         end
         grant[2]: begin
            sel_addr = req_addr[14:10];
            sel_data = req_data[3*width-1:2*width];
            next_ptr = 2'd0;
         end
         default: ;
      endcase
   end

   // Clear first, then set, so a same-edge issue keeps the register pending.
   always_comb begin
      busy_n = busy_q;
      if (xfer && sel_addr != 5'd0)
         busy_n[sel_addr] = 1'b0;
      if (issue_valid && issue_addr != 5'd0)
         busy_n[issue_addr] = 1'b1;
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= 2'd0;
         wr_enable <= 1'b0;
         W_addr    <= 5'd0;
         W_data    <= '0;
         busy_q    <= 32'd0;
      end else begin
         rr_ptr    <= next_ptr;
         wr_enable <= xfer && (sel_addr != 5'd0);
         busy_q    <= busy_n;
         if (xfer) begin
            W_addr <= sel_addr;
            W_data <= sel_data;
         end
      end
   end

   assign busy_vec = busy_q;
   assign A_busy   = busy_q[A_addr];
   assign B_busy   = busy_q[B_addr];

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: width, default 32, data width of the register file write port.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 Ports: req_valid[2:0]  input  3  writeback request per requester (0=ALU, 1=LOAD, 2=MULDIV).
REQ-005 Ports: req_addr[2:0]  input  3x5  destination register per requester.
REQ-006 Ports: req_data[2:0]  input  3xwidth  writeback data per requester.
REQ-007 Ports: req_ready[2:0]  output  3  grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1 on a clock edge.
REQ-008 Ports: W_addr  output  5, W_data  output  width, wr_enable  output  1  registered write port driving the regfile.
REQ-009 Ports: issue_valid  input  1, issue_addr  input  5  marks a destination register as pending.
REQ-010 Ports: A_addr, B_addr  input  5 each; A_busy, B_busy  output  1 each  pending status of the source registers.
REQ-011 Port: busy_vec  output  32  full scoreboard, bit n = register n pending.

Function
REQ-012 Exactly one requester, or none, SHALL be granted per cycle; req_ready SHALL be combinational from req_valid and the round-robin pointer.
REQ-013 Arbitration: round-robin; the search starts at rr_ptr and proceeds ascending mod 3; the first valid requester wins.
REQ-014 After a transfer by requester i, rr_ptr SHALL become (i+1) mod 3; with no transfer, rr_ptr SHALL hold.
REQ-015 req_ready[i] SHALL be 0 whenever req_valid[i] is 0.
REQ-016 Latency: a transfer at edge N SHALL present W_addr/W_data at edge N with wr_enable=1 for exactly one cycle, so the regfile writes at edge N+1.
REQ-017 With no transfer at an edge, wr_enable SHALL be 0 for the next cycle; W_addr and W_data SHALL hold their last values.
REQ-018 A transfer with req_addr=0 SHALL complete normally: it is granted, advances rr_ptr and drives W_addr/W_data, but wr_enable SHALL be 0.
REQ-019 Scoreboard set: issue_valid with issue_addr!=0 SHALL set busy_vec[issue_addr] at the edge; issue_addr=0 SHALL be ignored.
REQ-020 Scoreboard clear: a transfer to register r!=0 SHALL clear busy_vec[r] at the same edge as the transfer.
REQ-021 If a set and a clear target the same register at the same edge, the set SHALL win, leaving busy=1.
REQ-022 A set or clear on an already set or cleared bit SHALL be a no-op; no error is flagged.
REQ-023 busy_vec[0] SHALL be constant 0.
REQ-024 A_busy = busy_vec[A_addr] and B_busy = busy_vec[B_addr], combinational.
REQ-025 Requesters SHALL hold req_addr/req_data stable while req_valid=1 and req_ready=0; the block does not check this.

Reset
REQ-026 While reset=0: busy_vec=0, rr_ptr=0, wr_enable=0, W_addr=0, W_data=0; req_ready SHALL be all 0.
REQ-027 Reset asserted mid-transfer SHALL drop wr_enable asynchronously; the pending write is lost and busy bits are cleared.
REQ-028 The first edge after reset deassertion SHALL arbitrate normally starting from requester 0.

Verification
REQ-029 All three requesters valid continuously, with addrs 1/2/3, for 6 cycles -> grant order 0,1,2,0,1,2; W_addr sequence 1,2,3,1,2,3; wr_enable=1 every cycle.
REQ-030 issue_valid with addr 5 at edge N; LOAD writes reg 5 with data 0xDEADBEEF at edge N+3 -> A_busy (A_addr=5) is 1 for cycles N..N+2 and 0 from N+3; W_data=0xDEADBEEF with wr_enable=1 for cycle N+3.
REQ-031 issue of addr 7 and ALU writeback to reg 7 at the same edge -> busy_vec[7] remains 1.
REQ-032 MULDIV writeback to reg 0 -> req_ready[2]=1, rr_ptr advances to 0, wr_enable stays 0, busy_vec unchanged.
REQ-033 Only requester 1 valid for 3 cycles -> granted every cycle, rr_ptr=2 after each transfer; then all valid -> requester 2 is granted first.
REQ-034 reset pulsed low mid-stream with busy_vec=0x0000_00F0 -> busy_vec=0 and wr_enable=0 immediately, without waiting for a clock edge.
